// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared opcodes, FSM state type and operand-sign helpers for mul_sign_wrapper
package mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABS,
    ST_START,
    ST_WAIT,
    ST_FIX,
    ST_DONE,
    ST_DRAIN
  } state_t;

  // rs1 is signed for MULH and MULHSU; rs2 only for MULH. MULW works on zero-extended halves.
  function automatic logic a_is_signed(input logic [1:0] op, input logic word);
    return !word && (op == OP_MULH || op == OP_MULHSU);
  endfunction

  function automatic logic b_is_signed(input logic [1:0] op, input logic word);
    return !word && (op == OP_MULH);
  endfunction

endpackage

// File: rtl/twos_negate.sv
// rtl/twos_negate.sv - two's complement negation (~x + 1) of a Width-bit value
module twos_negate #(
  parameter int Width = 64
) (
  input  logic [Width-1:0] x,
  output logic [Width-1:0] y
);

  assign y = ~x + Width'(1);

endmodule

// File: rtl/mul_sign_wrapper.sv
// rtl/mul_sign_wrapper.sv - RV64M signed front/back end around the unsigned 64x64->128 multiplier core
module mul_sign_wrapper
  import mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [1:0]        op_i,
  input  logic              word_i,
  input  logic [XLEN-1:0]   a_i,
  input  logic [XLEN-1:0]   b_i,
  input  logic              flush_i,
  output logic              mul_start,
  output logic [XLEN-1:0]   mul_a,
  output logic [XLEN-1:0]   mul_b,
  input  logic              mul_done,
  input  logic [2*XLEN-1:0] mul_s,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [XLEN-1:0]   res_o
);

  localparam int Half = XLEN / 2;

  state_t              state;
  logic [1:0]          op_q;
  logic                word_q;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     b_q;
  logic                neg_p;
  logic [2*XLEN-1:0]   p_q;

  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     a_neg;
  logic [XLEN-1:0]     b_neg;
  logic [2*XLEN-1:0]   s_neg;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic [XLEN-1:0]     res_sel;

  twos_negate #(.Width(XLEN)) u_neg_a (
    .x (a_q),
    .y (a_neg)
  );

  twos_negate #(.Width(XLEN)) u_neg_b (
    .x (b_q),
    .y (b_neg)
  );

  twos_negate #(.Width(2*XLEN)) u_neg_p (
    .x (mul_s),
    .y (s_neg)
  );

  assign neg_a = a_q[XLEN-1] & a_is_signed(op_q, word_q);
  assign neg_b = b_q[XLEN-1] & b_is_signed(op_q, word_q);

  // The most negative value negates to itself, which is exactly its unsigned magnitude 2^(XLEN-1).
  always_comb begin
    mag_a = neg_a ? a_neg : a_q;
    mag_b = neg_b ? b_neg : b_q;
    if (word_q) begin
      mag_a = {{Half{1'b0}}, a_q[Half-1:0]};
      mag_b = {{Half{1'b0}}, b_q[Half-1:0]};
    end
  end

  always_comb begin
    res_sel = p_q[XLEN-1:0];
    if (word_q) begin
      res_sel = {{Half{p_q[Half-1]}}, p_q[Half-1:0]};
    end else if (op_q != OP_MUL) begin
      res_sel = p_q[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      op_q   <= OP_MUL;
      word_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      neg_p  <= 1'b0;
      p_q    <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      res_o  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (valid_i) begin
            op_q   <= op_i;
            word_q <= word_i;
            a_q    <= a_i;
            b_q    <= b_i;
            state  <= ST_ABS;
          end
        end
        ST_ABS: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            mul_a <= mag_a;
            mul_b <= mag_b;
            neg_p <= neg_a ^ neg_b;
            state <= ST_START;
          end
        end
        ST_START: begin
          state <= flush_i ? ST_IDLE : ST_WAIT;
        end
        ST_WAIT: begin
          // A flush that coincides with completion has nothing left to drain.
          if (flush_i && mul_done) begin
            state <= ST_IDLE;
          end else if (flush_i) begin
            state <= ST_DRAIN;
          end else if (mul_done) begin
            p_q   <= neg_p ? s_neg : mul_s;
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (flush_i) begin
            state <= ST_IDLE;
          end else begin
            res_o <= res_sel;
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flush_i || ready_i) begin
            state <= ST_IDLE;
          end
        end
        ST_DRAIN: begin
          if (mul_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign ready_o   = (state == ST_IDLE);
  assign valid_o   = (state == ST_DONE);
  assign mul_start = (state == ST_START);

endmodule

// File: tb/tb_mul_sign_wrapper.sv
// tb/tb_mul_sign_wrapper.sv - self-checking bench for mul_sign_wrapper with a variable-latency core model
module tb_mul_sign_wrapper;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid_i;
  logic         ready_o;
  logic [1:0]   op_i;
  logic         word_i;
  logic [63:0]  a_i;
  logic [63:0]  b_i;
  logic         flush_i;
  logic         mul_start;
  logic [63:0]  mul_a;
  logic [63:0]  mul_b;
  logic         mul_done;
  logic [127:0] mul_s;
  logic         valid_o;
  logic         ready_i;
  logic [63:0]  res_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int           core_lat = 4;
  int           core_cnt = 0;
  logic [127:0] core_prod;

  mul_sign_wrapper #(.XLEN(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .op_i      (op_i),
    .word_i    (word_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .flush_i   (flush_i),
    .mul_start (mul_start),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_done  (mul_done),
    .mul_s     (mul_s),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .res_o     (res_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Unsigned core: mul_done rises core_lat cycles after the mul_start cycle, for one cycle.
  initial begin
    mul_done  = 1'b0;
    mul_s     = '0;
    core_prod = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mul_done) begin
        mul_done = 1'b0;
        mul_s    = '0;
      end
      if (mul_start) begin
        core_cnt  = core_lat;
        core_prod = {64'b0, mul_a} * {64'b0, mul_b};
      end else if (core_cnt > 0) begin
        core_cnt = core_cnt - 1;
        if (core_cnt == 0) begin
          mul_done = 1'b1;
          mul_s    = core_prod;
        end
      end
    end
  end

  function automatic logic [63:0] ref_res(input logic [1:0] op, input logic word,
                                          input logic [63:0] a, input logic [63:0] b);
    logic [127:0] p;
    logic [63:0]  w;
    if (word) begin
      w = {32'b0, a[31:0]} * {32'b0, b[31:0]};
      return {{32{w[31]}}, w[31:0]};
    end
    case (op)
      2'd0:    p = {64'b0, a} * {64'b0, b};
      2'd1:    p = {{64{a[63]}}, a} * {{64{b[63]}}, b};
      2'd2:    p = {{64{a[63]}}, a} * {64'b0, b};
      default: p = {64'b0, a} * {64'b0, b};
    endcase
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  function automatic logic [63:0] ref_mag(input logic [63:0] x, input logic sgn, input logic word);
    if (word) return {32'b0, x[31:0]};
    if (sgn && x[63]) return 64'd0 - x;
    return x;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic launch(input logic [1:0] op, input logic word, input logic [63:0] a,
                        input logic [63:0] b, input int lat, output int s);
    s = -1;
    core_lat = lat;
    @(negedge clk);
    op_i = op; word_i = word; a_i = a; b_i = b; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (mul_start) begin
        s = cyc;
        break;
      end
      @(negedge clk);
    end
    if (s < 0) check_int("launch_start_timeout", 0, 1);
  endtask

  task automatic do_op(input string name, input logic [1:0] op, input logic word,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp_res,
                       input logic [63:0] exp_ma, input logic [63:0] exp_mb,
                       input int lat, input int stall);
    int k, s, d, v;
    logic [63:0] held;
    logic ok;
    s = -1; d = -1; v = -1;
    core_lat = lat;
    @(negedge clk);
    check({name, "_ready_idle"}, ready_o, 1);
    op_i = op; word_i = word; a_i = a; b_i = b; valid_i = 1'b1;
    k = cyc;
    @(negedge clk);
    valid_i = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (mul_start && s < 0) begin
        s = cyc;
        check({name, "_mul_a"}, mul_a, exp_ma);
        check({name, "_mul_b"}, mul_b, exp_mb);
      end
      if (mul_done && d < 0) d = cyc;
      if (valid_o) begin
        v = cyc;
        break;
      end
      @(negedge clk);
    end
    check_int({name, "_start_cycle"}, s, k + 2);
    if (v < 0) begin
      check_int({name, "_valid_timeout"}, 0, 1);
    end else begin
      check_int({name, "_valid_cycle"}, v, d + 2);
      check({name, "_res"}, res_o, exp_res);
      held = res_o;
      ok = 1'b1;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        if (!valid_o || res_o !== held || ready_o) ok = 1'b0;
      end
      if (stall > 0) check({name, "_stall_hold"}, ok, 1);
      ready_i = 1'b1;
      @(negedge clk);
      ready_i = 1'b0;
      check({name, "_post_valid"}, valid_o, 0);
      check({name, "_post_ready"}, ready_o, 1);
    end
  endtask

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] res;
    logic [63:0] ma;
    logic [63:0] mb;
  } vec_t;

  vec_t vt[5];

  initial begin
    int s;
    logic ok;
    logic seen;
    logic [1:0]  op;
    logic        word;
    logic [63:0] a;
    logic [63:0] b;

    vt[0] = '{"mulh_m1_m1",   2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h0, 64'h1, 64'h1};
    vt[1] = '{"mulhsu_m1_2",  2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
              64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h2};
    vt[2] = '{"mulhu_m1_2",   2'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2,
              64'h1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2};
    vt[3] = '{"mul_min_m1",   2'd0, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
              64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[4] = '{"mulw_wrap",    2'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'h2,
              64'hFFFF_FFFF_FFFF_FFFE, 64'h7FFF_FFFF, 64'h2};

    rst_n = 1'b0; valid_i = 1'b0; op_i = 2'd0; word_i = 1'b0; a_i = '0; b_i = '0;
    flush_i = 1'b0; ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", ready_o, 1);
    check("reset_valid", valid_o, 0);
    check("reset_start", mul_start, 0);
    check("reset_mul_a", mul_a, 0);
    check("reset_mul_b", mul_b, 0);
    check("reset_res", res_o, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 5; i++)
      do_op(vt[i].name, vt[i].op, vt[i].word, vt[i].a, vt[i].b, vt[i].res, vt[i].ma, vt[i].mb, 4, 0);

    // 9-cycle core with the consumer stalling for 5 cycles
    do_op("stall", 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_1234_5678,
          ref_res(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'h0000_0000_1234_5678),
          64'h7, 64'h0000_0000_1234_5678, 9, 5);

    // Flush three cycles into WAIT: drain the core, never present a result
    launch(2'd1, 1'b0, 64'h5, 64'h7, 9, s);
    repeat (4) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    ok = 1'b1; seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (valid_o) ok = 1'b0;
      if (mul_done) begin
        seen = 1'b1;
        break;
      end
      if (ready_o) ok = 1'b0;
      @(negedge clk);
    end
    check("drain_ready_low", ok, 1);
    check("drain_done_seen", seen, 1);
    @(negedge clk);
    check("drain_exit_ready", ready_o, 1);
    do_op("after_drain", 2'd3, 1'b0, 64'h3, 64'h5, 64'h0, 64'h3, 64'h5, 3, 1);

    // Flush and mul_done in the same WAIT cycle goes straight to IDLE
    launch(2'd0, 1'b0, 64'h9, 64'h9, 5, s);
    repeat (5) @(negedge clk);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    check("flush_done_ready", ready_o, 1);
    check("flush_done_valid", valid_o, 0);

    // Flush wins over ready_i in DONE
    launch(2'd0, 1'b0, 64'h9, 64'h9, 3, s);
    for (int i = 0; i < 20 && !valid_o; i++) @(negedge clk);
    check("flush_done_state_valid", valid_o, 1);
    flush_i = 1'b1; ready_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; ready_i = 1'b0;
    check("flush_in_done_valid", valid_o, 0);
    check("flush_in_done_ready", ready_o, 1);

    // Reset in WAIT, then a stray mul_done from the old job must be ignored
    launch(2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 9, s);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_wait_ready", ready_o, 1);
    check("rst_wait_valid", valid_o, 0);
    check("rst_wait_start", mul_start, 0);
    check("rst_wait_mul_a", mul_a, 0);
    check("rst_wait_mul_b", mul_b, 0);
    check("rst_wait_res", res_o, 0);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (valid_o || !ready_o || mul_start) ok = 1'b0;
    end
    check("stray_done_ignored", ok, 1);
    do_op("after_reset", 2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h4,
          ref_res(2'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'h4), 64'h3, 64'h4, 6, 0);

    // Randomized operations against the arithmetic reference
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      word = ($urandom_range(0, 4) == 0);
      if (word) op = 2'd0;
      case ($urandom_range(0, 5))
        0:       a = 64'h8000_0000_0000_0000;
        1:       a = '1;
        2:       a = '0;
        default: a = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 5))
        0:       b = 64'h8000_0000_0000_0000;
        1:       b = '1;
        2:       b = 64'h0000_0000_8000_0000;
        default: b = {$urandom, $urandom};
      endcase
      do_op($sformatf("rand%0d", i), op, word, a, b, ref_res(op, word, a, b),
            ref_mag(a, (op == 2'd1 || op == 2'd2), word), ref_mag(b, (op == 2'd1), word),
            int'($urandom_range(1, 12)), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
